cog_hub_port: RTL

Cog-side initiator for the hub memory interface. Accepts one byte/word/long read or write from the cog execution pipeline and drives the hub request strobes for the cog's hub port. It holds each strobe until the hub grants the cog's round-robin slot and returns read data to the cog. Writes are posted: the cog is released before the hub acknowledges them. A watchdog aborts any request the hub does not acknowledge.

---
 rtl/cog_hub_port.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cog_hub_port.sv
// Cog-side initiator for the hub memory port: holds one read or posted write strobe until the
// hub grants the slot, returns read data to the cog, and aborts requests the hub never acks.
module cog_hub_port #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        cog_req_in,
    input  logic        cog_we_in,
    input  logic [1:0]  cog_size_in,
    input  logic [16:0] cog_addr_in,
    input  logic [31:0] cog_wdata_in,
    output logic        cog_busy_o,
    output logic        cog_done_o,
    output logic [31:0] cog_rdata_o,
    output logic        cog_err_o,
    output logic [16:0] hub_mem_addr_o,
    output logic [31:0] hub_mem_data_o,
    output logic [1:0]  hub_mem_size_o,
    output logic        hub_mem_read_o,
    output logic        hub_mem_write_o,
    input  logic        hub_mem_ack_in,
    input  logic [31:0] hub_mem_data_in
);

    typedef enum logic [1:0] {
        StIdle,
        StRdReq,
        StRdData,
        StWrReq
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  wdog_q;
    logic              wdog_expired;

    assign wdog_expired = (wdog_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q         <= StIdle;
            wdog_q          <= '0;
            cog_busy_o      <= 1'b0;
            cog_done_o      <= 1'b0;
            cog_rdata_o     <= '0;
            cog_err_o       <= 1'b0;
            hub_mem_addr_o  <= '0;
            hub_mem_data_o  <= '0;
            hub_mem_size_o  <= '0;
            hub_mem_read_o  <= 1'b0;
            hub_mem_write_o <= 1'b0;
        end else begin
            cog_done_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cog_req_in) begin
                        hub_mem_addr_o <= cog_addr_in;
                        hub_mem_size_o <= cog_size_in;
                        hub_mem_data_o <= cog_wdata_in;
                        wdog_q         <= '0;
                        cog_err_o      <= 1'b0;
                        cog_busy_o     <= 1'b1;
                        if (cog_we_in) begin
                            // Posted write: release the cog on the accept edge.
                            state_q         <= StWrReq;
                            hub_mem_write_o <= 1'b1;
                            cog_done_o      <= 1'b1;
                        end else begin
                            state_q        <= StRdReq;
                            hub_mem_read_o <= 1'b1;
                        end
                    end
                end
                StRdReq: begin
                    if (hub_mem_ack_in) begin
                        hub_mem_read_o <= 1'b0;
                        state_q        <= StRdData;
                    end else if (wdog_expired) begin
                        hub_mem_read_o <= 1'b0;
                        cog_err_o      <= 1'b1;
                        cog_done_o     <= 1'b1;
                        cog_rdata_o    <= '0;
                        cog_busy_o     <= 1'b0;
                        state_q        <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StRdData: begin
                    // Hub data is valid the cycle after its ack.
                    cog_rdata_o <= hub_mem_data_in;
                    cog_done_o  <= 1'b1;
                    cog_busy_o  <= 1'b0;
                    state_q     <= StIdle;
                end
                StWrReq: begin
                    if (hub_mem_ack_in) begin
                        hub_mem_write_o <= 1'b0;
                        cog_busy_o      <= 1'b0;
                        state_q         <= StIdle;
                    end else if (wdog_expired) begin
                        hub_mem_write_o <= 1'b0;
                        cog_err_o       <= 1'b1;
                        cog_busy_o      <= 1'b0;
                        state_q         <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: begin
                    hub_mem_read_o  <= 1'b0;
                    hub_mem_write_o <= 1'b0;
                    cog_busy_o      <= 1'b0;
                    state_q         <= StIdle;
                end
            endcase
        end
    end

endmodule
